// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 types, forward S-box and the round helper functions.
// Provides aes_state_t/aes_byte_t, sbox(), sub_bytes(), shift_rows() and key_add().
// Byte order: byte0 = state[127:120], column-major (byte k = row k%4, column k/4).
package aes_pkg;

  localparam int AES_BLOCK = 128;
  localparam int AES_NB    = 4;

  typedef logic [AES_BLOCK-1:0] aes_state_t;
  typedef logic [7:0]           aes_byte_t;

  localparam aes_byte_t SBOX_TBL [0:255] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  function automatic aes_byte_t sbox(input aes_byte_t b);
    return SBOX_TBL[b];
  endfunction

  function automatic aes_state_t sub_bytes(input aes_state_t s);
    aes_state_t r;
    r = '0;
    for (int k = 0; k < 4 * AES_NB; k++) begin
      r[127 - 8*k -: 8] = sbox(s[127 - 8*k -: 8]);
    end
    return r;
  endfunction

  // Row r rotates left by r columns: out(r,c) = in(r,(c+r) mod 4).
  function automatic aes_state_t shift_rows(input aes_state_t s);
    aes_state_t r;
    r = '0;
    for (int c = 0; c < AES_NB; c++) begin
      for (int w = 0; w < 4; w++) begin
        r[127 - 8*(4*c + w) -: 8] = s[127 - 8*(4*((c + w) % AES_NB) + w) -: 8];
      end
    end
    return r;
  endfunction

  function automatic aes_state_t key_add(input aes_state_t s, input aes_state_t k);
    return s ^ k;
  endfunction

endpackage

// File: rtl/round_10_enc_pipe_slice.sv
// r10_pipe_slice: one valid/ready register stage (payload + valid flag).
// Latency 1 cycle; a full slice refills in the same cycle it drains, so no bubbles.
// Backpressure: in_ready = !valid || out_ready; payload holds while out_ready is low.
// Ports: in_valid/in_ready/in_data upstream, out_valid/out_ready/out_data downstream.
module r10_pipe_slice #(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         load;

  always_comb begin
    in_ready = !valid_q || out_ready;
    load     = in_valid && in_ready;
    // Valid clears only when the stage drains without being refilled.
    valid_d  = load || (valid_q && !out_ready);
    data_d   = load ? in_data : data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/round_10_enc_pipe.sv
// round_10_enc_pipe: final AES-128 encryption round, OUT = ShiftRows(SubBytes(IN)) ^ KEY.
// Latency 2 cycles (S1: SubBytes + key capture, S2: ShiftRows + key add); 1 block/cycle.
// Backpressure: out_ready low stalls S2 then S1; in_ready is combinational from out_ready,
// unless AES_R10_ENC_SKID_EN is defined, which adds a 1-entry input skid and a registered in_ready.
// Ports: clk, rst (async, active-high), in_valid/in_ready/IN/KEY, out_valid/out_ready/OUT.
module round_10_enc_pipe
  import aes_pkg::*;
#(
  parameter int BLOCK_LENGTH = 128
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BLOCK_LENGTH-1:0] IN,
  input  logic [BLOCK_LENGTH-1:0] KEY,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BLOCK_LENGTH-1:0] OUT
);

  logic       s1_in_valid, s1_in_ready, s1_valid, s2_ready;
  aes_state_t s1_src_state, s1_src_key;
  aes_state_t s1_state, s1_key;

`ifdef AES_R10_ENC_SKID_EN
  logic       skid_valid_q, skid_valid_d;
  aes_state_t skid_state_q, skid_state_d;
  aes_state_t skid_key_q, skid_key_d;
  logic       accept;

  always_comb begin
    in_ready     = !skid_valid_q;
    accept       = in_valid && !skid_valid_q;
    // Skid contents always go first; the input is only accepted while the skid is empty.
    s1_in_valid  = skid_valid_q || in_valid;
    s1_src_state = skid_valid_q ? skid_state_q : IN;
    s1_src_key   = skid_valid_q ? skid_key_q : KEY;
    skid_valid_d = !s1_in_ready && (skid_valid_q || accept);
    skid_state_d = (accept && !s1_in_ready) ? IN  : skid_state_q;
    skid_key_d   = (accept && !s1_in_ready) ? KEY : skid_key_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_valid_q <= 1'b0;
      skid_state_q <= '0;
      skid_key_q   <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_state_q <= skid_state_d;
      skid_key_q   <= skid_key_d;
    end
  end
`else
  always_comb begin
    in_ready     = s1_in_ready;
    s1_in_valid  = in_valid;
    s1_src_state = IN;
    s1_src_key   = KEY;
  end
`endif

  r10_pipe_slice #(.W(2 * AES_BLOCK)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_in_valid),
    .in_ready  (s1_in_ready),
    .in_data   ({sub_bytes(s1_src_state), s1_src_key}),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  ({s1_state, s1_key})
  );

  r10_pipe_slice #(.W(AES_BLOCK)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   (key_add(shift_rows(s1_state), s1_key)),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (OUT)
  );

endmodule

// File: tb/tb_round_10_enc_pipe.sv
module tb_round_10_enc_pipe;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_dat = '0;
  logic [127:0] key_dat = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_dat;

  int total = 0;
  int bad   = 0;
  logic [127:0] q[$];

  localparam logic [127:0] V_IN  = 128'heb40f21e592e38848ba113e71bc342d2;
  localparam logic [127:0] V_KEY = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] V_OUT = 128'h3925841d02dc09fbdc118597196a0b32;

  // Only IN byte15 changes with i; it lands in OUT byte3 as sbox(d2^i)^a8.
  logic [7:0] exp_b3 [8] = '{8'h1d, 8'hce, 8'hd8, 8'h96, 8'h5e, 8'ha6, 8'he0, 8'hab};

  round_10_enc_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .IN        (in_dat),
    .KEY       (key_dat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .OUT       (out_dat)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] stream_exp(input int i);
    logic [7:0] b;
    b = exp_b3[i];
    return {24'h392584, b, 96'h02dc09fbdc118597196a0b32};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock of stimulus: drive at negedge, sample in_ready, record accepted block at posedge.
  task automatic drive(input logic v, input logic [127:0] din, input logic [127:0] kin,
                       input logic ordy, input logic [127:0] exp, output logic rdy);
    @(negedge clk);
    in_valid  = v;
    in_dat    = din;
    key_dat   = kin;
    out_ready = ordy;
    #1 rdy = in_ready;
    @(posedge clk);
    if (v && rdy) q.push_back(exp);
  endtask

  task automatic drain();
    logic r;
    for (int n = 0; n < 40 && q.size() > 0; n++) drive(1'b0, '0, '0, 1'b1, '0, r);
    chk("drain_queue_empty", 128'(q.size()), 128'd0);
  endtask

  task automatic lat_test(input string name, input logic [127:0] din,
                          input logic [127:0] kin, input logic [127:0] exp);
    @(negedge clk);
    in_valid  = 1'b1;
    in_dat    = din;
    key_dat   = kin;
    out_ready = 1'b1;
    #1 chk({name, "_in_ready"}, 128'(in_ready), 128'd1);
    @(posedge clk);
    q.push_back(exp);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk({name, "_valid_after_1"}, 128'(out_valid), 128'd0);
    @(negedge clk);
    #1 chk({name, "_valid_after_2"}, 128'(out_valid), 128'd1);
    drain();
  endtask

  // Scoreboard monitor: pops on transfer, checks the held word while stalled.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got %h with no block outstanding", out_dat);
        end else if (out_ready) begin
          chk("out_data", out_dat, q.pop_front());
        end else begin
          chk("stall_hold", out_dat, q[0]);
        end
      end
    end
  end

`ifdef AES_R10_ENC_SKID_EN
  always @(in_ready) begin
    if (!rst && ($time % 10) != 5) begin
      total++;
      bad++;
      $display("FAIL in_ready_off_edge: changed to %b at time %0t", in_ready, $time);
    end
  end
`endif

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic r;
    int   j;
    #1;
    chk("reset_in_ready", 128'(in_ready), 128'd1);
    chk("reset_out_valid", 128'(out_valid), 128'd0);
    chk("reset_out", out_dat, 128'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single block, FIPS-197 App. B.
    lat_test("single", V_IN, V_KEY, V_OUT);

    // Back-to-back streaming with out_ready held high.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, V_IN ^ 128'(i), V_KEY, 1'b1, stream_exp(i), r);
      chk("stream_in_ready", 128'(r), 128'd1);
    end
    drain();

    // Backpressure: out_ready low for cycles 2..6 while input keeps offering.
    j = 0;
    for (int k = 0; k < 60 && j < 8; k++) begin
      drive(1'b1, V_IN ^ 128'(j), V_KEY, !(k >= 2 && k < 7), stream_exp(j), r);
      if (k == 6) chk("bp_in_ready_low", 128'(r), 128'd0);
      if (r) j++;
    end
    chk("bp_all_accepted", 128'(j), 128'd8);
    drain();

    // Zero vector.
    lat_test("zero", '0, '0, {16{8'h63}});

    // Reset mid-stream with the pipeline full.
    for (int k = 0; k < 4; k++) drive(1'b1, V_IN, V_KEY, 1'b0, V_OUT, r);
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 128'(out_valid), 128'd0);
    chk("midrst_out", out_dat, 128'd0);
    chk("midrst_in_ready", 128'(in_ready), 128'd1);
    q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    lat_test("post_reset", V_IN, V_KEY, V_OUT);

    chk("final_queue_empty", 128'(q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
